// File: rtl/reorder_buffer_if.sv
// Handshake bundle between rename/dispatch, writeback units and the reorder buffer.
// The ROB side uses the slave modport; the pipeline/driver side uses master.
interface reorder_buffer_if #(
    parameter int DEPTH  = 32,
    parameter int PREG_W = 7
);
    localparam int TAG_W = $clog2(DEPTH);

    logic              alloc_valid;
    logic              alloc_ready;
    logic [PREG_W-1:0] alloc_pd_new;
    logic [PREG_W-1:0] alloc_pd_old;
    logic [31:0]       alloc_pc;
    logic [TAG_W-1:0]  alloc_tag;

    logic              alu_done;
    logic [TAG_W-1:0]  alu_tag;
    logic              mem_done;
    logic [TAG_W-1:0]  mem_tag;
    logic              b_done;
    logic [TAG_W-1:0]  b_tag;
    logic              mispredict;
    logic [TAG_W-1:0]  mispredict_tag;

    logic              commit_valid;
    logic [PREG_W-1:0] commit_pd_new;
    logic [PREG_W-1:0] commit_pd_old;
    logic [31:0]       commit_pc;
    logic [TAG_W-1:0]  commit_tag;
    logic              rob_empty;
    logic              rob_full;
    logic [31:0]       perf_commit_cnt;
    logic [31:0]       perf_stall_cnt;

    modport master (
        output alloc_valid, alloc_pd_new, alloc_pd_old, alloc_pc,
        output alu_done, alu_tag, mem_done, mem_tag, b_done, b_tag,
        output mispredict, mispredict_tag,
        input  alloc_ready, alloc_tag,
        input  commit_valid, commit_pd_new, commit_pd_old, commit_pc, commit_tag,
        input  rob_empty, rob_full, perf_commit_cnt, perf_stall_cnt
    );

    modport slave (
        input  alloc_valid, alloc_pd_new, alloc_pd_old, alloc_pc,
        input  alu_done, alu_tag, mem_done, mem_tag, b_done, b_tag,
        input  mispredict, mispredict_tag,
        output alloc_ready, alloc_tag,
        output commit_valid, commit_pd_new, commit_pd_old, commit_pc, commit_tag,
        output rob_empty, rob_full, perf_commit_cnt, perf_stall_cnt
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: allocate at tail, complete by tag, retire at head,
// squash younger entries on mispredict. Define ROB_PERF_CNT_EN to build the perf counters.
module reorder_buffer #(
    parameter int DEPTH  = 32,
    parameter int PREG_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    reorder_buffer_if.slave  rob
);
    localparam int TAG_W = $clog2(DEPTH);
    localparam int CNT_W = TAG_W + 1;

    logic [PREG_W-1:0] pd_new_q [DEPTH];
    logic [PREG_W-1:0] pd_new_d [DEPTH];
    logic [PREG_W-1:0] pd_old_q [DEPTH];
    logic [PREG_W-1:0] pd_old_d [DEPTH];
    logic [31:0]       pc_q     [DEPTH];
    logic [31:0]       pc_d     [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  complete_q, complete_d;
    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              full;
    logic              alloc_fire;
    logic              commit_fire;
    logic              mp_fire;
    logic [TAG_W-1:0]  mp_age;

    assign full        = (count_q == CNT_W'(DEPTH));
    // Reset wins over retirement so nothing leaves the ROB in the cycle it is flushed.
    assign commit_fire = valid_q[head_q] && complete_q[head_q] && !reset;
    assign mp_fire     = rob.mispredict && valid_q[rob.mispredict_tag];
    assign alloc_fire  = rob.alloc_valid && !full && !mp_fire;
    assign mp_age      = rob.mispredict_tag - head_q;

    assign rob.alloc_ready   = !full;
    assign rob.alloc_tag     = tail_q;
    assign rob.rob_full      = full;
    assign rob.rob_empty     = (count_q == '0);
    assign rob.commit_valid  = commit_fire;
    assign rob.commit_pd_new = commit_fire ? pd_new_q[head_q] : '0;
    assign rob.commit_pd_old = commit_fire ? pd_old_q[head_q] : '0;
    assign rob.commit_pc     = commit_fire ? pc_q[head_q]     : '0;
    assign rob.commit_tag    = commit_fire ? head_q           : '0;

    always_comb begin
        pd_new_d   = pd_new_q;
        pd_old_d   = pd_old_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        complete_d = complete_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (rob.alu_done && valid_q[rob.alu_tag]) complete_d[rob.alu_tag] = 1'b1;
        if (rob.mem_done && valid_q[rob.mem_tag]) complete_d[rob.mem_tag] = 1'b1;
        if (rob.b_done   && valid_q[rob.b_tag])   complete_d[rob.b_tag]   = 1'b1;

        if (alloc_fire) begin
            pd_new_d[tail_q]   = rob.alloc_pd_new;
            pd_old_d[tail_q]   = rob.alloc_pd_old;
            pc_d[tail_q]       = rob.alloc_pc;
            valid_d[tail_q]    = 1'b1;
            complete_d[tail_q] = 1'b0;
            tail_d             = tail_q + TAG_W'(1);
        end

        // Anything older-than-head-relative age beyond the branch is younger and gets squashed,
        // which also discards completions that landed on those tags this cycle.
        if (mp_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((TAG_W'(i) - head_q) > mp_age) begin
                    valid_d[i]    = 1'b0;
                    complete_d[i] = 1'b0;
                end
            end
            complete_d[rob.mispredict_tag] = 1'b1;
            tail_d = rob.mispredict_tag + TAG_W'(1);
        end

        if (commit_fire) begin
            valid_d[head_q]    = 1'b0;
            complete_d[head_q] = 1'b0;
            head_d             = head_q + TAG_W'(1);
        end

        if (mp_fire) begin
            count_d = CNT_W'(mp_age) + CNT_W'(1) - CNT_W'(commit_fire);
        end else begin
            count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pd_new_q[i] <= '0;
                pd_old_q[i] <= '0;
                pc_q[i]     <= '0;
            end
            valid_q    <= '0;
            complete_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            pd_new_q   <= pd_new_d;
            pd_old_q   <= pd_old_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            complete_q <= complete_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_commit_q, perf_commit_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_commit_d = perf_commit_q + 32'(commit_fire);
        perf_stall_d  = perf_stall_q + 32'(rob.alloc_valid && full);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_commit_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_commit_q <= perf_commit_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign rob.perf_commit_cnt = perf_commit_q;
    assign rob.perf_stall_cnt  = perf_stall_q;
`else
    assign rob.perf_commit_cnt = '0;
    assign rob.perf_stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocations push expected retirements into a queue,
// a negedge monitor pops and compares every commit the ROB presents.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reorder_buffer_if #(.DEPTH(32), .PREG_W(7)) rob ();
    reorder_buffer #(.DEPTH(32), .PREG_W(7)) dut (.clk(clk), .reset(reset), .rob(rob));

    typedef struct packed {
        logic [4:0]  tag;
        logic [6:0]  pd_new;
        logic [6:0]  pd_old;
        logic [31:0] pc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [4:0] tb_tail;
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && rob.commit_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL commit_unexpected actual_tag=%0d required=none", rob.commit_tag);
            end else begin
                mon_e = exp_q.pop_front();
                chk("commit_tag",    32'(rob.commit_tag),    32'(mon_e.tag));
                chk("commit_pd_new", 32'(rob.commit_pd_new), 32'(mon_e.pd_new));
                chk("commit_pd_old", 32'(rob.commit_pd_old), 32'(mon_e.pd_old));
                chk("commit_pc",     rob.commit_pc,          mon_e.pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rob.alloc_valid = 1'b0; rob.alloc_pd_new = '0; rob.alloc_pd_old = '0; rob.alloc_pc = '0;
        rob.alu_done = 1'b0; rob.alu_tag = '0; rob.mem_done = 1'b0; rob.mem_tag = '0;
        rob.b_done = 1'b0; rob.b_tag = '0; rob.mispredict = 1'b0; rob.mispredict_tag = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        tb_tail = '0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic do_alloc(input logic [6:0] pn, input logic [6:0] po, input logic [31:0] pc);
        chk("alloc_tag", 32'(rob.alloc_tag), 32'(tb_tail));
        rob.alloc_valid = 1'b1; rob.alloc_pd_new = pn; rob.alloc_pd_old = po; rob.alloc_pc = pc;
        exp_q.push_back('{tag: tb_tail, pd_new: pn, pd_old: po, pc: pc});
        tb_tail = tb_tail + 5'd1;
        cyc();
        rob.alloc_valid = 1'b0;
    endtask

    task automatic complete_alu(input logic [4:0] tag);
        rob.alu_done = 1'b1; rob.alu_tag = tag;
        cyc();
        rob.alu_done = 1'b0;
    endtask

    task automatic mp_model(input logic [4:0] tag);
        while (exp_q.size() > 0 && exp_q[$].tag != tag) void'(exp_q.pop_back());
        tb_tail = tag + 5'd1;
    endtask

    task automatic chk_perf(input string name, input logic [31:0] act, input int on_val);
`ifdef ROB_PERF_CNT_EN
        chk(name, act, 32'(on_val));
`else
        chk(name, act, 32'd0);
`endif
    endtask

    initial begin
        idle();
        tb_tail = '0;
        do_reset();

        // T1: reset state
        chk("t1_empty",        32'(rob.rob_empty),    1);
        chk("t1_full",         32'(rob.rob_full),     0);
        chk("t1_alloc_ready",  32'(rob.alloc_ready),  1);
        chk("t1_commit_valid", 32'(rob.commit_valid), 0);
        chk("t1_alloc_tag",    32'(rob.alloc_tag),    0);
        chk("t1_perf_commit",  rob.perf_commit_cnt,   0);

        // T2: out-of-order completion, in-order retirement
        do_alloc(7'd33, 7'd1, 32'h1000);
        do_alloc(7'd34, 7'd2, 32'h1004);
        do_alloc(7'd35, 7'd3, 32'h1008);
        complete_alu(5'd1);
        chk("t2_no_commit_tag1_only", 32'(rob.commit_valid), 0);
        rob.mem_done = 1'b1; rob.mem_tag = 5'd0;
        cyc();
        rob.mem_done = 1'b0;
        chk("t2_commit0_valid", 32'(rob.commit_valid), 1);
        chk("t2_commit0_tag",   32'(rob.commit_tag),   0);
        cyc();
        chk("t2_commit1_valid", 32'(rob.commit_valid), 1);
        chk("t2_commit1_tag",   32'(rob.commit_tag),   1);
        cyc();
        chk("t2_tag2_held",     32'(rob.commit_valid), 0);
        chk("t2_not_empty",     32'(rob.rob_empty),    0);
        rob.b_done = 1'b1; rob.b_tag = 5'd2;
        cyc();
        rob.b_done = 1'b0;
        chk("t2_commit2_tag",   32'(rob.commit_tag),   2);
        cyc();
        chk("t2_empty",         32'(rob.rob_empty),    1);
        chk("t2_drained",       32'(exp_q.size()),     0);

        // T3: fill, stall, wrap
        do_reset();
        for (int i = 0; i < 32; i++) do_alloc(7'(i), 7'(i + 64), 32'h2000 + 32'(4 * i));
        chk("t3_full",         32'(rob.rob_full),    1);
        chk("t3_alloc_ready",  32'(rob.alloc_ready), 0);
        chk("t3_alloc_tag",    32'(rob.alloc_tag),   0);
        rob.alloc_valid = 1'b1; rob.alloc_pd_new = 7'd127; rob.alloc_pd_old = 7'd127;
        rob.alloc_pc = 32'hdead;
        cyc();
        rob.alloc_valid = 1'b0;
        chk("t3_still_full",   32'(rob.rob_full),    1);
        chk_perf("t3_perf_stall", rob.perf_stall_cnt, 1);
        complete_alu(5'd0);
        chk("t3_commit_valid", 32'(rob.commit_valid), 1);
        chk("t3_full_despite_commit", 32'(rob.alloc_ready), 0);
        cyc();
        chk("t3_ready_after_commit", 32'(rob.alloc_ready), 1);
        chk_perf("t3_perf_commit", rob.perf_commit_cnt, 1);
        do_alloc(7'd100, 7'd101, 32'h3000);
        chk("t3_full_again",   32'(rob.rob_full),    1);

        // T4: mispredict squash with same-cycle completion and alloc
        do_reset();
        for (int i = 0; i < 10; i++) do_alloc(7'(i + 10), 7'(i + 20), 32'h4000 + 32'(4 * i));
        rob.b_done = 1'b1; rob.b_tag = 5'd4; rob.mispredict = 1'b1; rob.mispredict_tag = 5'd4;
        rob.alu_done = 1'b1; rob.alu_tag = 5'd7;
        rob.alloc_valid = 1'b1; rob.alloc_pd_new = 7'd99; rob.alloc_pc = 32'hbad;
        cyc();
        idle();
        mp_model(5'd4);
        chk("t4_alloc_tag",   32'(rob.alloc_tag),    5);
        chk("t4_not_empty",   32'(rob.rob_empty),    0);
        chk("t4_no_commit",   32'(rob.commit_valid), 0);
        rob.alu_done = 1'b1; rob.alu_tag = 5'd0;
        rob.mem_done = 1'b1; rob.mem_tag = 5'd1;
        rob.b_done   = 1'b1; rob.b_tag   = 5'd2;
        cyc();
        idle();
        complete_alu(5'd3);
        repeat (6) cyc();
        chk("t4_empty_after_5", 32'(rob.rob_empty),    1);
        chk("t4_tag7_gone",     32'(rob.commit_valid), 0);
        do_alloc(7'd50, 7'd51, 32'h5000);
        complete_alu(5'd5);
        cyc();
        chk("t4_empty_end",     32'(rob.rob_empty),    1);
        chk("t4_drained",       32'(exp_q.size()),     0);

        // T5: wrapped mispredict at tag 31, then mispredict on an invalid tag
        do_reset();
        for (int i = 0; i < 30; i++) do_alloc(7'(i), 7'(i + 1), 32'h6000 + 32'(4 * i));
        for (int i = 0; i < 30; i++) complete_alu(5'(i));
        repeat (2) cyc();
        chk("t5_empty_pre",  32'(rob.rob_empty), 1);
        for (int i = 0; i < 4; i++) do_alloc(7'(i + 90), 7'(i + 80), 32'h7000 + 32'(4 * i));
        rob.b_done = 1'b1; rob.b_tag = 5'd31; rob.mispredict = 1'b1; rob.mispredict_tag = 5'd31;
        cyc();
        idle();
        mp_model(5'd31);
        chk("t5_tail_wrap",  32'(rob.alloc_tag), 0);
        chk("t5_not_empty",  32'(rob.rob_empty), 0);
        complete_alu(5'd30);
        repeat (2) cyc();
        chk("t5_empty_after_2", 32'(rob.rob_empty),    1);
        chk("t5_no_commit",     32'(rob.commit_valid), 0);
        rob.b_done = 1'b1; rob.b_tag = 5'd5; rob.mispredict = 1'b1; rob.mispredict_tag = 5'd5;
        cyc();
        idle();
        chk("t5_invalid_mp_tail",  32'(rob.alloc_tag), 0);
        chk("t5_invalid_mp_empty", 32'(rob.rob_empty), 1);
        chk("t5_drained",          32'(exp_q.size()),  0);

        // T6: reset with entries in flight and a commit pending
        do_reset();
        for (int i = 0; i < 10; i++) do_alloc(7'(i + 5), 7'(i + 40), 32'h8000 + 32'(4 * i));
        complete_alu(5'd0);
        reset = 1'b1;
        exp_q.delete();
        tb_tail = '0;
        #1;
        chk("t6_no_commit_in_reset", 32'(rob.commit_valid), 0);
        cyc();
        chk("t6_empty",        32'(rob.rob_empty),    1);
        chk("t6_commit_valid", 32'(rob.commit_valid), 0);
        chk("t6_alloc_tag",    32'(rob.alloc_tag),    0);
        chk("t6_perf_commit",  rob.perf_commit_cnt,   0);
        chk("t6_perf_stall",   rob.perf_stall_cnt,    0);
        reset = 1'b0;
        cyc();
        chk("t6_empty_post",   32'(rob.rob_empty),    1);
        chk("t6_commit_post",  32'(rob.commit_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
